main_mem_responder: RTL and testbench

//   Multi-cycle main-memory responder: the far end of the CPU-side memory request interface.

---
 rtl/wisc_mem_pkg.sv | 19 +
 rtl/mem_array_1rw.sv | 38 +++
 rtl/main_mem_responder.sv | 175 +++++++++++++++++
 tb/tb_main_mem_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_mem_pkg.sv
// Shared definitions for the main-memory responder slice.
//   state_e       : responder FSM states (ST_IDLE, ST_WAIT, ST_BURST, ST_DONE)
//   DEF_LATENCY   : default accept-to-first-beat / accept-to-wr_done latency
//   DEF_BURST_LEN : default words per block fill
//   BLK_OFF_BITS  : word-offset bits within a default-sized block
package wisc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned DEF_LATENCY   = 4;
  localparam int unsigned DEF_BURST_LEN = 8;
  localparam int unsigned BLK_OFF_BITS  = $clog2(DEF_BURST_LEN);

endpackage

// File: rtl/mem_array_1rw.sv
// Synchronous single-port word storage: one read or one write per cycle.
// Contents are never reset; read data is registered (one-cycle read latency).
// Ports:
//   clk_i    clock, rising edge
//   en_i     access enable
//   we_i     1 = write wdata_i at idx_i, 0 = read idx_i into rdata_o
//   idx_i    word index
//   wdata_i  write data
//   rdata_o  read data from the most recent read access
module mem_array_1rw #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned DEPTH  = 32768,
  parameter int unsigned IDX_W  = 15
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[idx_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/main_mem_responder.sv
// Multi-cycle main-memory responder. Serves block-fill reads as fixed-latency
// bursts of BURST_LEN words and single-word writes with a one-cycle wr_done.
// One request outstanding at a time; req_ready is high only when idle.
// Build option: define MAIN_MEM_CWF_EN for critical-word-first read bursts
// (beat 0 is the requested word, offsets wrap within the block); otherwise
// bursts always start at block offset 0.
// Ports:
//   clk, rst (async, active-high)
//   req_valid/req_ready/req_wr/req_addr/req_wdata : request channel
//   rsp_valid/rsp_data/rsp_addr/rsp_last          : read beat channel
//   wr_done : write-commit pulse;  busy : ~req_ready
module main_mem_responder
  import wisc_mem_pkg::*;
#(
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned AWIDTH    = 16,
  parameter int unsigned LATENCY   = DEF_LATENCY,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN,
  parameter int unsigned MEM_WORDS = 65536 / 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_data,
  output logic [AWIDTH-1:0] rsp_addr,
  output logic              rsp_last,
  output logic              wr_done,
  output logic              busy
);

  localparam int unsigned OFF_BITS = $clog2(BURST_LEN);
  localparam int unsigned IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [AWIDTH-1:0] BLK_MASK  = AWIDTH'((1 << (OFF_BITS + 1)) - 1);
  localparam logic [AWIDTH-1:0] WORD_MASK = AWIDTH'(1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    lat_q, lat_d;
  logic [OFF_BITS-1:0] beat_q, beat_d;
  logic [AWIDTH-1:0]   cur_q, cur_d;            // next address to access
  logic [AWIDTH-1:0]   beat_addr_q, beat_addr_d; // address of the beat on rsp_*
  logic                wr_q, wr_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;

  logic                mem_en, mem_we;
  logic [DWIDTH-1:0]   mem_rdata;
  logic [AWIDTH-1:0]   rd_start;

`ifdef MAIN_MEM_CWF_EN
  assign rd_start = req_addr & ~WORD_MASK;
`else
  assign rd_start = req_addr & ~BLK_MASK;
`endif

  // Advance the word offset and wrap inside the block; the block bits never
  // change, so the same step serves both the linear and the wrapped order.
  function automatic logic [AWIDTH-1:0] next_addr(input logic [AWIDTH-1:0] a);
    logic [AWIDTH-1:0]   n;
    logic [OFF_BITS-1:0] off;
    n   = a;
    off = a[OFF_BITS:1] + OFF_BITS'(1);
    n[OFF_BITS:1] = off;
    return n;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [AWIDTH-1:0] a);
    logic [31:0] w;
    w = 32'(a >> 1);
    return IDX_W'(w % 32'(MEM_WORDS));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lat_q       <= '0;
      beat_q      <= '0;
      cur_q       <= '0;
      beat_addr_q <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      beat_q      <= beat_d;
      cur_q       <= cur_d;
      beat_addr_q <= beat_addr_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
    end
  end

  // Storage reads run one cycle ahead of the visible beat: the read for
  // beat k is issued on the cycle before beat k is presented.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    beat_d      = beat_q;
    cur_d       = cur_q;
    beat_addr_d = beat_addr_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_WAIT;
          lat_d   = CNT_W'(LATENCY - 1);
          wr_d    = req_wr;
          wdata_d = req_wdata;
          cur_d   = req_wr ? (req_addr & ~WORD_MASK) : rd_start;
          beat_d  = '0;
        end
      end
      ST_WAIT: begin
        if (lat_q == '0) begin
          if (wr_q) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_BURST;
            mem_en      = 1'b1;
            beat_addr_d = cur_q;
            cur_d       = next_addr(cur_q);
          end
        end else begin
          lat_d = lat_q - CNT_W'(1);
        end
      end
      ST_BURST: begin
        if (beat_q == '1) begin
          state_d = ST_IDLE;
        end else begin
          beat_d      = beat_q + OFF_BITS'(1);
          mem_en      = 1'b1;
          beat_addr_d = cur_q;
          cur_d       = next_addr(cur_q);
        end
      end
      ST_DONE: begin
        mem_en  = 1'b1;
        mem_we  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  mem_array_1rw #(
    .DWIDTH (DWIDTH),
    .DEPTH  (MEM_WORDS),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk_i   (clk),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .idx_i   (word_idx(cur_q)),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  // Outputs decode straight from state so an async reset clears them at once.
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = ~req_ready;
  assign rsp_valid = (state_q == ST_BURST);
  assign rsp_last  = rsp_valid && (beat_q == '1);
  assign rsp_data  = rsp_valid ? mem_rdata : '0;
  assign rsp_addr  = rsp_valid ? beat_addr_q : '0;
  assign wr_done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_main_mem_responder.sv
module tb_main_mem_responder;

  localparam int LAT = 4;
  localparam int BL  = 8;

  logic        clk, rst;
  logic        req_valid, req_ready, req_wr;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_last, wr_done, busy;
  logic [15:0] rsp_data, rsp_addr;

  main_mem_responder #(
    .DWIDTH    (16),
    .AWIDTH    (16),
    .LATENCY   (LAT),
    .BURST_LEN (BL),
    .MEM_WORDS (32768)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .rsp_last  (rsp_last),
    .wr_done   (wr_done),
    .busy      (busy)
  );

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [15:0] data;
    bit          chk;
    bit          last;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mdl[int];
  int unsigned cyc;
  int          total, bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Scoreboard monitor: every rsp beat or wr_done pops one expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && (rsp_valid || wr_done)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {30'd0, rsp_valid, wr_done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("kind_wr_done", {31'd0, wr_done}, {31'd0, e.is_wr});
        check("event_cycle", cyc, e.cyc);
        if (e.is_wr) begin
          check("rsp_valid_on_write", {31'd0, rsp_valid}, 32'd0);
        end else begin
          check("rsp_addr", {16'd0, rsp_addr}, {16'd0, e.addr});
          check("rsp_last", {31'd0, rsp_last}, {31'd0, e.last});
          if (e.chk) check("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
        end
      end
    end
  end

  task automatic do_req(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                        output int unsigned acc);
    int          n;
    logic [15:0] base, a;
    logic [2:0]  start, off;
    int          idx;
    exp_t        e;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 300) begin
      check("busy_while_not_ready", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    acc       = cyc;
    req_valid = 1'b0;
    if (wr) begin
      e = '{is_wr: 1'b1, addr: addr & 16'hFFFE, data: wd, chk: 1'b0, last: 1'b0, cyc: acc + LAT};
      exp_q.push_back(e);
      mdl[int'(addr >> 1)] = wd;
    end else begin
      base = addr & 16'hFFF0;
`ifdef MAIN_MEM_CWF_EN
      start = addr[3:1];
`else
      start = 3'd0;
`endif
      for (int k = 0; k < BL; k++) begin
        off = start + 3'(k);
        a   = base | {12'd0, off, 1'b0};
        idx = int'(a >> 1);
        e.is_wr = 1'b0;
        e.addr  = a;
        e.chk   = mdl.exists(idx);
        e.data  = e.chk ? mdl[idx] : 16'h0000;
        e.last  = (k == BL - 1);
        e.cyc   = acc + LAT + k;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_last"},  {31'd0, rsp_last},  32'd0);
    check({tag, "_wr_done"},   {31'd0, wr_done},   32'd0);
    check({tag, "_rsp_data"},  {16'd0, rsp_data},  32'd0);
    check({tag, "_rsp_addr"},  {16'd0, rsp_addr},  32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned acc, acc_a, acc_b;
    logic [15:0] old;
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    #12;
    check_reset_outputs("in_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("after_reset");

    // Preload blocks 0x0030, 0x0100 and 0xFFF0 through the write path.
    for (int i = 0; i < BL; i++) do_req(1'b1, 16'h0030 + 16'(2 * i), 16'h1000 + 16'(i * 17), acc);
    for (int i = 0; i < BL; i++) do_req(1'b1, 16'h0100 + 16'(2 * i), 16'h2000 + 16'(i * 3), acc);
    for (int i = 0; i < BL; i++) do_req(1'b1, 16'hFFF0 + 16'(2 * i), 16'h3000 + 16'(i * 5), acc);
    wait_idle();

    // Read inside block 0x0030.
    do_req(1'b0, 16'h0034, 16'h0000, acc);
    wait_idle();

    // Single write then read of its block (0xBEEF lands on beat 1).
    do_req(1'b1, 16'h0102, 16'hBEEF, acc);
    do_req(1'b0, 16'h0100, 16'h0000, acc);
    wait_idle();

    // Address wrap at the top of the space.
    do_req(1'b0, 16'hFFF6, 16'h0000, acc);
    wait_idle();

    // Back-to-back: second request held high through the first burst.
    do_req(1'b0, 16'h0030, 16'h0000, acc_a);
    do_req(1'b0, 16'h0106, 16'h0000, acc_b);
    check("b2b_accept_cycle", acc_b, acc_a + LAT + BL + 1);
    wait_idle();

    // Reset asserted during beat 3 of a burst.
    do_req(1'b0, 16'h0034, 16'h0000, acc);
    while (cyc < acc + LAT + 3) begin @(posedge clk); #1; end
    @(negedge clk); #1;
    check("beat3_valid_before_rst", {31'd0, rsp_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_burst_rst");
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("post_burst_rst");

    // Write aborted during the latency wait must leave storage intact.
    old = mdl[int'(16'h0104 >> 1)];
    do_req(1'b1, 16'h0104, 16'hDEAD, acc);
    @(posedge clk); #1;
    check("abort_in_wait_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("wait_rst");
    exp_q.delete();
    mdl[int'(16'h0104 >> 1)] = old;
    @(posedge clk); #1;
    rst = 1'b0;
    do_req(1'b0, 16'h0100, 16'h0000, acc);
    wait_idle();

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
